mem_readback_engine: RTL and testbench

//  Read-side counterpart of the word-by-word image loader that fills mainMem before execution.
//  On a start pulse it issues sequential word reads to a mainMem read port (wren held 0).
//  It streams each {address, data} pair out over a valid/ready handshake.

---
 rtl/mem_readback_engine.sv | 149 ++++++++++++++
 tb/tb_mem_readback_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readback_engine.sv
// mem_readback_engine
// Streams a block of mainMem words out as {address, data} beats. After a
// start request it walks word-aligned addresses upward, issuing one read per
// word, waits READ_LATENCY non-busy cycles for the data, and holds each
// captured word on a valid/ready output until the consumer takes it.
// READ_LATENCY must lie in 1..7 (it is loaded into a 3-bit countdown).

module mem_readback_engine #(
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [0:31]      base_addr,
  input  logic [0:CNT_W-1] word_count,
  output logic [0:31]      mem_addr,
  output logic             mem_enable,
  output logic             mem_wren,
  output logic [0:1]       mem_acc_size,
  input  logic             mem_busy,
  input  logic [0:31]      mem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:31]      out_addr,
  output logic [0:31]      out_data,
  output logic             active,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [2:0]       LAT_LOAD = 3'(READ_LATENCY);
  localparam logic [0:CNT_W-1] CNT_ONE  = CNT_W'(1);
  localparam logic [0:CNT_W-1] CNT_ZERO = '0;

  // Byte address forced onto a word boundary; the two low bits are dropped.
  function automatic logic [0:31] word_align(input logic [0:31] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Next word address; wraps from 32'hFFFFFFFC to 0 by plain modular add.
  function automatic logic [0:31] next_word(input logic [0:31] a);
    return a + 32'd4;
  endfunction

  // Remaining-word count after one beat is accepted (CNT_W-bit unsigned).
  function automatic logic [0:CNT_W-1] dec_count(input logic [0:CNT_W-1] c);
    return c - CNT_ONE;
  endfunction

  logic [2:0]       state;
  logic [0:31]      addr;
  logic [0:CNT_W-1] rem;
  logic [2:0]       lat;

  logic handshake;
  logic last_word;
  logic capture;

  assign handshake = (state == S_HOLD) && out_ready;
  assign last_word = (rem == CNT_ONE);
  assign capture   = (state == S_WAIT) && !mem_busy && (lat == 3'd1);

  // Sequencer: state, latency countdown and remaining-word counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      rem   <= CNT_ZERO;
      lat   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem   <= word_count;
            state <= (word_count == CNT_ZERO) ? S_FIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!mem_busy) begin
            lat   <= LAT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_busy) begin
            lat <= lat - 3'd1;
            if (lat == 3'd1) begin
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            rem   <= dec_count(rem);
            state <= last_word ? S_FIN : S_ISSUE;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Address walker: latched on start, advanced one word per accepted beat.
  // Cleared on reset so mem_addr reads back as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= 32'd0;
    end else if ((state == S_IDLE) && start) begin
      addr <= word_align(base_addr);
    end else if (handshake) begin
      addr <= next_word(addr);
    end
  end

  // Output word register: captures the read result when the countdown
  // expires and stays frozen through HOLD until the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_addr <= 32'd0;
      out_data <= 32'd0;
    end else if (capture) begin
      out_addr <= addr;
      out_data <= mem_data;
    end
  end

  // Status and memory strobes decoded straight from the state register.
  always_comb begin
    mem_enable = (state == S_ISSUE) || (state == S_WAIT);
    out_valid  = (state == S_HOLD);
    done       = (state == S_FIN);
    active     = (state != S_IDLE);
  end

  assign mem_addr     = addr;
  assign mem_wren     = 1'b0;
  assign mem_acc_size = 2'b00;

endmodule

// File: tb/tb_mem_readback_engine.sv
// Bench for mem_readback_engine: a latency-aware mainMem model, a reference
// model tracking expected beats in a queue, and directed scenarios with
// hand-computed addresses, data and cycle counts.

module tb_mem_readback_engine;

  localparam int RL    = 2;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [0:31]      base_addr;
  logic [0:CNT_W-1] word_count;
  logic [0:31]      mem_addr;
  logic             mem_enable;
  logic             mem_wren;
  logic [0:1]       mem_acc_size;
  logic             mem_busy;
  logic [0:31]      mem_data;
  logic             out_valid;
  logic             out_ready;
  logic [0:31]      out_addr;
  logic [0:31]      out_data;
  logic             active;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;
  int lat_cnt  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  mem_readback_engine #(
    .READ_LATENCY(RL),
    .CNT_W       (CNT_W)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .mem_addr    (mem_addr),
    .mem_enable  (mem_enable),
    .mem_wren    (mem_wren),
    .mem_acc_size(mem_acc_size),
    .mem_busy    (mem_busy),
    .mem_data    (mem_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .active      (active),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: four preloaded words, everything else a fixed address hash.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h8002_0000: return 32'h1111_1111;
      32'h8002_0004: return 32'h2222_2222;
      32'h8002_0008: return 32'h3333_3333;
      32'h8002_000C: return 32'h4444_4444;
      default:       return a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Read port: data is only valid after RL non-busy cycles of a held strobe.
  always @(posedge clk) begin
    if (!mem_enable) lat_cnt <= 0;
    else if (!mem_busy && lat_cnt < 7) lat_cnt <= lat_cnt + 1;
  end

  always_comb begin
    mem_data = 32'hDEAD_BEEF;
    if (mem_enable && lat_cnt >= RL) mem_data = mem_val(mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle-level reference: beats expected after a start, done after the last one.
  task automatic monitor();
    beat_t       q[$];
    beat_t       b;
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    logic        pv = 1'b0;
    logic        ph = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    logic [31:0] a0;
    forever begin
      @(negedge clk);
      chk("wren", 32'(mem_wren), 32'd0);
      chk("acc_size", 32'(mem_acc_size), 32'd0);
      chk("active", 32'(active), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      if (out_valid) begin
        chk("valid_allowed", 32'(m_active && !m_done && q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          chk("beat_addr", out_addr, q[0].a);
          chk("beat_data", out_data, q[0].d);
        end
      end
      if (pv && !ph) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_addr", out_addr, pa);
        chk("hold_data", out_data, pd);
      end
      if (mem_enable) begin
        chk("enable_allowed", 32'(m_active && !m_done && !out_valid && q.size() > 0), 32'd1);
        if (q.size() > 0) chk("read_addr", mem_addr, q[0].a);
      end
      pv = out_valid && !reset;
      ph = out_valid && out_ready;
      pa = out_addr;
      pd = out_data;
      if (reset) begin
        q.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
      end else if (m_done) begin
        m_active = 1'b0;
        m_done   = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        a0 = base_addr & 32'hFFFF_FFFC;
        for (int k = 0; k < int'(word_count); k++) begin
          b.a = a0 + 32'(4 * k);
          b.d = mem_val(b.a);
          q.push_back(b);
        end
        if (word_count == 0) m_done = 1'b1;
      end else if (m_active && ph && q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end
  endtask

  task automatic run_start(input logic [31:0] base, input int cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(cnt);
    tick();
    start      = 1'b0;
    base_addr  = 32'hA5A5_A5A5;
    word_count = CNT_W'(7);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // Wait for a beat, check its latency and content, then let it be accepted.
  task automatic beat(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                      input int elat);
    int n;
    wait_valid(20, n);
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_addr"}, out_addr, ea);
    chk({tag, "_data"}, out_data, ed);
    tick();
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_active"}, 32'(active), 32'd1);
    tick();
    chk({tag, "_done_end"}, 32'(done), 32'd0);
    chk({tag, "_active_end"}, 32'(active), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_addr"}, out_addr, 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    mem_busy   = 1'b0;
    out_ready  = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    reset = 1'b0;
    fork
      monitor();
    join_none
    tick();

    // Four-word dump with a free-flowing consumer.
    out_ready = 1'b1;
    run_start(32'h8002_0000, 4);
    beat("t1_b0", 32'h8002_0000, 32'h1111_1111, 3);
    beat("t1_b1", 32'h8002_0004, 32'h2222_2222, 3);
    beat("t1_b2", 32'h8002_0008, 32'h3333_3333, 3);
    beat("t1_b3", 32'h8002_000C, 32'h4444_4444, 3);
    expect_done("t1");
    tick();

    // Consumer stalls for five cycles on the second beat.
    run_start(32'h8002_0000, 4);
    beat("t2_b0", 32'h8002_0000, 32'h1111_1111, 3);
    out_ready = 1'b0;
    wait_valid(20, n);
    chk("t2_b1_lat", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 32'(out_valid), 32'd1);
      chk("t2_stall_addr", out_addr, 32'h8002_0004);
      chk("t2_stall_data", out_data, 32'h2222_2222);
      chk("t2_stall_noread", 32'(mem_enable), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    beat("t2_b2", 32'h8002_0008, 32'h3333_3333, 3);
    beat("t2_b3", 32'h8002_000C, 32'h4444_4444, 3);
    expect_done("t2");
    tick();

    // Zero-length request: no memory access, done right after start.
    run_start(32'h1234_5678, 0);
    chk("t3_no_read", 32'(mem_enable), 32'd0);
    expect_done("t3");
    chk("t3_no_read_end", 32'(mem_enable), 32'd0);
    tick();

    // Unaligned base near the top of the address space wraps to zero.
    run_start(32'hFFFF_FFFE, 2);
    beat("t4_b0", 32'hFFFF_FFFC, 32'hA5A5_F0F3, 3);
    beat("t4_b1", 32'h0000_0000, 32'h5A5A_0F0F, 3);
    expect_done("t4");
    tick();

    // Busy for three cycles while waiting on the read.
    run_start(32'h8002_0008, 1);
    tick();
    mem_busy = 1'b1;
    repeat (3) tick();
    mem_busy = 1'b0;
    beat("t5_busy_wait", 32'h8002_0008, 32'h3333_3333, 2);
    expect_done("t5a");
    tick();

    // Busy for two cycles while the read is being issued.
    run_start(32'h8002_000C, 1);
    mem_busy = 1'b1;
    repeat (2) tick();
    mem_busy = 1'b0;
    beat("t5_busy_issue", 32'h8002_000C, 32'h4444_4444, 3);
    expect_done("t5b");
    tick();

    // Reset while the second of four words is held, then a fresh run.
    run_start(32'h8002_0000, 4);
    beat("t6_b0", 32'h8002_0000, 32'h1111_1111, 3);
    out_ready = 1'b0;
    wait_valid(20, n);
    chk("t6_in_hold", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_zero("t6_abort");
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_done", 32'(done), 32'd0);
      tick();
    end
    run_start(32'h8002_0004, 3);
    beat("t6_r0", 32'h8002_0004, 32'h2222_2222, 3);
    beat("t6_r1", 32'h8002_0008, 32'h3333_3333, 3);
    beat("t6_r2", 32'h8002_000C, 32'h4444_4444, 3);
    expect_done("t6");
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
